// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner and IF/ID pipeline register with stall, flush and
//               branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] PCResult,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_q + 32'd4;

  // Redirect outranks stall; a stalled flush still drops IF/ID contents.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (BranchTaken) begin
      pc_d         = {BranchTarget[31:2], 2'b00};
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (Stall) begin
      if (Flush) begin
        ifid_instr_d = NOP_WORD;
        ifid_pc4_d   = 32'd0;
        ifid_valid_d = 1'b0;
      end
    end else begin
      pc_d = w_pc_plus4;
      if (Flush) begin
        ifid_instr_d = NOP_WORD;
        ifid_pc4_d   = 32'd0;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d = Instruction;
        ifid_pc4_d   = w_pc_plus4;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign Address           = pc_q;
  assign PCResult          = pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PCPlus4     = ifid_pc4_q;
  assign IF_ID_Valid       = ifid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench for instruction_fetch_unit; memory word i = i*3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction;
  logic [31:0] Address, PCResult, IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_Valid;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // 128-word memory aliased on Address[8:2], word i holds i*3
  assign Instruction = {25'd0, Address[8:2]} * 32'd3;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .Instruction      (Instruction),
    .Address          (Address),
    .PCResult         (PCResult),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                         input logic [31:0] pc4, input logic vld);
    chk({tag, ".addr"}, Address, addr);
    chk({tag, ".pcres"}, PCResult, addr);
    chk({tag, ".instr"}, IF_ID_Instruction, ins);
    chk({tag, ".pc4"}, IF_ID_PCPlus4, pc4);
    chk({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, vld});
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0;
    #1;
    chk_all("reset_async", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); step();
    chk_all("reset_held", 32'h0, 32'h0, 32'h0, 1'b0);

    Reset = 1'b0;
    step(); chk_all("fetch0", 32'h4, 32'd0, 32'h4, 1'b1);
    step(); chk_all("fetch1", 32'h8, 32'd3, 32'h8, 1'b1);

    Stall = 1'b1;
    step(); chk_all("stall1", 32'h8, 32'd3, 32'h8, 1'b1);
    step(); chk_all("stall2", 32'h8, 32'd3, 32'h8, 1'b1);
    Stall = 1'b0;
    step(); chk_all("unstall", 32'hC, 32'd6, 32'hC, 1'b1);

    BranchTaken = 1'b1; BranchTarget = 32'h43; Stall = 1'b1;
    step(); chk_all("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
    BranchTaken = 1'b0; Stall = 1'b0;
    step(); chk_all("br_fetch", 32'h44, 32'd48, 32'h44, 1'b1);

    BranchTaken = 1'b1; BranchTarget = 32'h20;
    step(); chk_all("br_20", 32'h20, 32'h0, 32'h0, 1'b0);
    BranchTaken = 1'b0;
    step(); chk_all("fetch_20", 32'h24, 32'd24, 32'h24, 1'b1);
    BranchTaken = 1'b1; BranchTarget = 32'h20;
    step();
    BranchTaken = 1'b0; Flush = 1'b1;
    step(); chk_all("flush", 32'h24, 32'h0, 32'h0, 1'b0);
    Flush = 1'b0;
    step(); chk_all("post_flush", 32'h28, 32'd27, 32'h28, 1'b1);

    Stall = 1'b1; Flush = 1'b1;
    step(); chk_all("stall_flush", 32'h28, 32'h0, 32'h0, 1'b0);
    Stall = 1'b0; Flush = 1'b0;

    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step(); chk_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    BranchTaken = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'd381, 32'h0, 1'b1);
    step(); chk_all("after_wrap", 32'h4, 32'd0, 32'h4, 1'b1);

    BranchTaken = 1'b1; BranchTarget = 32'h2C;
    step();
    BranchTaken = 1'b0;
    step(); chk_all("fetch_2c", 32'h30, 32'd33, 32'h30, 1'b1);
    Stall = 1'b1;
    step(); chk_all("stall_30", 32'h30, 32'd33, 32'h30, 1'b1);

    // Mid-cycle async reset with a pending redirect
    #2;
    Reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
    #1;
    chk_all("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); chk_all("reset_br", 32'h0, 32'h0, 32'h0, 1'b0);
    BranchTaken = 1'b0; Stall = 1'b0;
    Reset = 1'b0;
    step(); chk_all("rerelease", 32'h4, 32'd0, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
